// File: rtl/norm1_sqsum_window.sv
// norm1_sqsum_window: 5-channel sum-of-squares window (in_x/in_valid/in_ready in, out_sum/out_x/out_last/out_valid/out_ready out)
module norm1_sqsum_window #(
  parameter int DIN_W = 11,
  parameter int SUM_W = 25,
  parameter int NCH   = 96
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [DIN_W-1:0] in_x,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [DIN_W-1:0] out_x,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int SQ_W = 2 * DIN_W;
  localparam int CW = $clog2(NCH);
  localparam logic [1:0] FILL = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] in_ch;
  logic dph;
  logic [SQ_W-1:0] sq [1:4];
  logic [DIN_W-1:0] xw [3:4];
  logic free, accept, drain_step, produce;
  logic [DIN_W-1:0] x_in;
  logic [SQ_W-1:0] sq_in;
  logic [SUM_W-1:0] sum_nx;
  assign free = !out_valid || out_ready;
  assign in_ready = ap_rst_n && (state == FILL || (state == RUN && free));
  assign accept = in_valid && in_ready;
  assign drain_step = state == DRAIN && free;
  assign produce = drain_step || (accept && state == RUN);
  assign x_in = drain_step ? '0 : in_x;
  assign sq_in = SQ_W'(x_in) * SQ_W'(x_in);
  assign sum_nx = SUM_W'(sq[1]) + SUM_W'(sq[2]) + SUM_W'(sq[3]) + SUM_W'(sq[4]) + SUM_W'(sq_in);
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      for (int i = 1; i <= 4; i++) sq[i] <= '0;
      xw[3] <= '0;
      xw[4] <= '0;
    end else if (drain_step && dph) begin
      for (int i = 1; i <= 4; i++) sq[i] <= '0;
      xw[3] <= '0;
      xw[4] <= '0;
    end else if (accept || drain_step) begin
      for (int i = 1; i <= 3; i++) sq[i] <= sq[i+1];
      sq[4] <= sq_in;
      xw[3] <= xw[4];
      xw[4] <= x_in;
    end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state <= FILL;
      in_ch <= '0;
      dph <= 1'b0;
    end else if (accept) begin
      in_ch <= in_ch + 1'b1;
      if (state == FILL && in_ch == CW'(1)) state <= RUN;
      if (state == RUN && in_ch == CW'(NCH - 1)) state <= DRAIN;
    end else if (drain_step) begin
      dph <= !dph;
      if (dph) begin
        state <= FILL;
        in_ch <= '0;
      end
    end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_sum <= '0;
      out_x <= '0;
      out_last <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_sum <= sum_nx;
      out_x <= xw[3];
      out_last <= drain_step && dph;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_norm1_sqsum_window.sv
// tb_norm1_sqsum_window: randomized and directed checks of norm1_sqsum_window against a window-sum model
module tb_norm1_sqsum_window;
  typedef struct {
    longint s;
    longint x;
    longint l;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [10:0] in_x [3];
  logic in_valid [3];
  logic in_ready [3];
  logic [24:0] out_sum [3];
  logic [10:0] out_x [3];
  logic out_last [3];
  logic out_valid [3];
  logic out_ready [3];
  exp_t expq[$];
  longint got[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    norm1_sqsum_window #(.NCH(g == 0 ? 5 : g == 1 ? 7 : 96)) dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_x(in_x[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .out_sum(out_sum[g]), .out_x(out_x[g]), .out_last(out_last[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g])
    );
  end
  function automatic int nch(input int s);
    return s == 0 ? 5 : s == 1 ? 7 : 96;
  endfunction
  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n)
      for (int s = 0; s < 3; s++)
        if (out_valid[s] && out_ready[s]) begin : mon
          exp_t e;
          if (expq.size() == 0) check("extra_out", 1, 0);
          else begin
            e = expq.pop_front();
            check("out_sum", longint'(out_sum[s]), e.s);
            check("out_x", longint'(out_x[s]), e.x);
            check("out_last", longint'(out_last[s]), e.l);
            got.push_back(longint'(out_sum[s]));
          end
        end
  task automatic wait_empty();
    int cyc = 0;
    while (expq.size() > 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drained", expq.size(), 0);
  endtask
  task automatic run_pixel(input int s, input int mode, input int vp, input int rp, input int stall_at, input bit drain_chk);
    int n = nch(s);
    int xs[];
    int c = 0;
    int cyc = 0;
    bit acc;
    bit stalled = 0;
    longint hs, hx;
    xs = new[n];
    for (int i = 0; i < n; i++)
      xs[i] = mode == 0 ? i + 1 : mode == 1 ? 2047 : mode == 2 ? 0 :
              ($urandom_range(3) == 0 ? 2047 : int'($urandom_range(2047)));
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.s = 0;
      for (int j = i - 2; j <= i + 2; j++)
        if (j >= 0 && j < n) e.s += longint'(xs[j]) * xs[j];
      e.x = xs[i];
      e.l = i == n - 1;
      expq.push_back(e);
    end
    while (c < n && cyc < 5000) begin
      if (c == stall_at && !stalled) begin
        stalled = 1;
        out_ready[s] = 1'b0;
        in_valid[s] = 1'b1;
        in_x[s] = 11'(xs[c]);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) begin
            hs = out_sum[s];
            hx = out_x[s];
            check("stall_ov", out_valid[s], 1);
          end else begin
            check("stall_sum", longint'(out_sum[s]), hs);
            check("stall_x", longint'(out_x[s]), hx);
          end
          check("stall_rdy", in_ready[s], 0);
          @(posedge clk);
          #1;
        end
      end
      in_x[s] = 11'(xs[c]);
      in_valid[s] = $urandom_range(99) < vp;
      out_ready[s] = $urandom_range(99) < rp;
      @(negedge clk);
      acc = in_valid[s] && in_ready[s];
      @(posedge clk);
      #1;
      if (acc) c++;
      cyc++;
    end
    if (c < n) check("feed_timeout", c, n);
    in_valid[s] = 1'b0;
    out_ready[s] = 1'b1;
    if (drain_chk)
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("drain_rdy", in_ready[s], k == 2);
      end
    wait_empty();
  endtask
  task automatic check_ramp(input string tag);
    int t[5] = '{14, 30, 55, 54, 50};
    check({tag, "_cnt"}, got.size(), 5);
    if (got.size() == 5)
      for (int i = 0; i < 5; i++) check(tag, got[i], t[i]);
  endtask
  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_x[s] = '0;
      in_valid[s] = 1'b0;
      out_ready[s] = 1'b1;
    end
    #1;
    for (int s = 0; s < 3; s++) begin
      check("rst_rdy", in_ready[s], 0);
      check("rst_ov", out_valid[s], 0);
      check("rst_sum", longint'(out_sum[s]), 0);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("first_rdy", in_ready[0], 1);
    @(posedge clk);
    #1;
    got.delete();
    run_pixel(0, 0, 100, 100, -1, 1);
    check_ramp("ramp_sum");
    got.delete();
    run_pixel(0, 2, 100, 100, -1, 1);
    for (int i = 0; i < got.size(); i++) check("zero_pix", got[i], 0);
    check("zero_cnt", got.size(), 5);
    got.delete();
    run_pixel(2, 1, 100, 100, -1, 1);
    check("max_cnt", got.size(), 96);
    if (got.size() == 96) begin
      check("max_c0", got[0], 12570627);
      check("max_c1", got[1], 16760836);
      check("max_c50", got[50], 20951045);
      check("max_c94", got[94], 16760836);
      check("max_c95", got[95], 12570627);
    end
    run_pixel(0, 3, 100, 100, 3, 0);
    run_pixel(1, 3, 100, 100, 4, 0);
    for (int p = 0; p < 20; p++) run_pixel(1, 3, 60, 50, -1, 0);
    for (int p = 0; p < 6; p++) run_pixel(0, 3, 70, 60, -1, 0);
    out_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_x[0] = 11'(k + 7);
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("pre_rst_ov", out_valid[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", out_valid[0], 0);
    check("mid_rst_sum", longint'(out_sum[0]), 0);
    check("mid_rst_rdy", in_ready[0], 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    run_pixel(0, 0, 100, 100, -1, 1);
    check_ramp("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
